// File: rtl/byteswap_ctrl_pkg.sv
// Shared definitions for the byteswap kernel AXI4-Lite control slave:
// register map offsets, CTRL bit positions, FSM state types and a byte-strobe merge helper.
package byteswap_ctrl_pkg;

  localparam int unsigned ADDR_CTRL     = 'h00;
  localparam int unsigned ADDR_GIER     = 'h04;
  localparam int unsigned ADDR_IER      = 'h08;
  localparam int unsigned ADDR_ISR      = 'h0C;
  localparam int unsigned ADDR_SCALAR00 = 'h10;
  localparam int unsigned ADDR_PTR0_LO  = 'h18;
  localparam int unsigned ADDR_PTR0_HI  = 'h1C;

  localparam int unsigned CTRL_AP_START     = 0;
  localparam int unsigned CTRL_DONE_STICKY  = 1;
  localparam int unsigned CTRL_AP_IDLE      = 2;
  localparam int unsigned CTRL_AP_READY     = 3;
  localparam int unsigned CTRL_AUTO_RESTART = 7;

  typedef enum logic [1:0] {
    WIDLE = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    RIDLE = 1'b0,
    RDATA = 1'b1
  } rd_state_t;

  // Replace only the bytes of old whose strobe bit is set.
  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/byteswap_control_s_axi.sv
// AXI4-Lite control slave for the byteswap kernel: ap_ctrl handshake, scalar00 and axi00_ptr0.
// Optional interrupt block (GIER/IER/ISR) enabled by defining BYTESWAP_CTRL_IRQ_EN.
module byteswap_control_s_axi
  import byteswap_ctrl_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 64
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_axi_control_awvalid,
  output logic                          s_axi_control_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_control_awaddr,
  input  logic                          s_axi_control_wvalid,
  output logic                          s_axi_control_wready,
  input  logic [31:0]                   s_axi_control_wdata,
  input  logic [3:0]                    s_axi_control_wstrb,
  output logic                          s_axi_control_bvalid,
  input  logic                          s_axi_control_bready,
  output logic [1:0]                    s_axi_control_bresp,
  input  logic                          s_axi_control_arvalid,
  output logic                          s_axi_control_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_control_araddr,
  output logic                          s_axi_control_rvalid,
  input  logic                          s_axi_control_rready,
  output logic [31:0]                   s_axi_control_rdata,
  output logic [1:0]                    s_axi_control_rresp,
  output logic                          ap_start,
  input  logic                          ap_done,
  input  logic                          ap_idle,
  input  logic                          ap_ready,
  output logic [C_XFER_SIZE_WIDTH-1:0]  scalar00,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] axi00_ptr0,
  output logic                          interrupt
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  wr_state_t     wr_state, wr_state_n;
  rd_state_t     rd_state, rd_state_n;
  logic [AW-1:0] wr_addr;
  logic          aw_hs, w_hs, ar_hs;

  logic          ap_start_q;
  logic          auto_restart;
  logic          done_sticky;
  logic [31:0]   scalar_q;
  logic [63:0]   ptr_q;
  logic [31:0]   rdata_q, rdata_n;

  // ---------------------------------------------------------------- write FSM
  assign s_axi_control_awready = !areset && (wr_state == WIDLE);
  assign s_axi_control_wready  = !areset && (wr_state == WDATA);
  assign s_axi_control_bvalid  = !areset && (wr_state == WRESP);
  assign s_axi_control_bresp   = 2'b00;

  assign aw_hs = s_axi_control_awvalid && s_axi_control_awready;
  assign w_hs  = s_axi_control_wvalid  && s_axi_control_wready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) wr_state <= WIDLE;
    else        wr_state <= wr_state_n;
  end

  // NOTE: defaulting next-state to the current state first keeps this block latch-free.
  always_comb begin
    wr_state_n = wr_state;
    unique case (wr_state)
      WIDLE:   if (aw_hs) wr_state_n = WDATA;
      WDATA:   if (w_hs) wr_state_n = WRESP;
      WRESP:   if (s_axi_control_bready) wr_state_n = WIDLE;
      default: wr_state_n = WIDLE;
    endcase
  end

  // NOTE: wr_addr has no reset; it is only consumed after a fresh AW handshake reloads it.
  always_ff @(posedge aclk) begin
    if (aw_hs) wr_addr <= s_axi_control_awaddr;
  end

  logic wsel_ctrl, wsel_scalar, wsel_ptr_lo, wsel_ptr_hi;
  assign wsel_ctrl   = w_hs && (wr_addr == AW'(ADDR_CTRL));
  assign wsel_scalar = w_hs && (wr_addr == AW'(ADDR_SCALAR00));
  assign wsel_ptr_lo = w_hs && (wr_addr == AW'(ADDR_PTR0_LO));
  assign wsel_ptr_hi = w_hs && (wr_addr == AW'(ADDR_PTR0_HI));

  // ----------------------------------------------------------------- read FSM
  assign s_axi_control_arready = !areset && (rd_state == RIDLE);
  assign s_axi_control_rvalid  = !areset && (rd_state == RDATA);
  assign s_axi_control_rdata   = rdata_q;
  assign s_axi_control_rresp   = 2'b00;

  assign ar_hs = s_axi_control_arvalid && s_axi_control_arready;

  always_ff @(posedge aclk) begin
    if (areset) rd_state <= RIDLE;
    else        rd_state <= rd_state_n;
  end

  always_comb begin
    rd_state_n = rd_state;
    unique case (rd_state)
      RIDLE:   if (ar_hs) rd_state_n = RDATA;
      RDATA:   if (s_axi_control_rready) rd_state_n = RIDLE;
      default: rd_state_n = RIDLE;
    endcase
  end

  // ------------------------------------------------------------ control bits
  // A start request beats a concurrent ap_ready so a host write is never lost.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ap_start_q   <= 1'b0;
      auto_restart <= 1'b0;
      done_sticky  <= 1'b0;
    end else begin
      if (wsel_ctrl && s_axi_control_wstrb[0] && s_axi_control_wdata[CTRL_AP_START])
        ap_start_q <= 1'b1;
      else if (ap_ready && !auto_restart)
        ap_start_q <= 1'b0;

      if (wsel_ctrl && s_axi_control_wstrb[0])
        auto_restart <= s_axi_control_wdata[CTRL_AUTO_RESTART];

      if (ap_done)
        done_sticky <= 1'b1;
      else if (ar_hs && (s_axi_control_araddr == AW'(ADDR_CTRL)))
        done_sticky <= 1'b0;
    end
  end

  assign ap_start = ap_start_q;

  // -------------------------------------------------------- argument registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      scalar_q <= '0;
      ptr_q    <= '0;
    end else begin
      if (wsel_scalar)
        scalar_q <= apply_strb(scalar_q, s_axi_control_wdata, s_axi_control_wstrb);
      if (wsel_ptr_lo)
        ptr_q[31:0] <= apply_strb(ptr_q[31:0], s_axi_control_wdata, s_axi_control_wstrb);
      if (wsel_ptr_hi)
        ptr_q[63:32] <= apply_strb(ptr_q[63:32], s_axi_control_wdata, s_axi_control_wstrb);
    end
  end

  assign scalar00   = scalar_q[C_XFER_SIZE_WIDTH-1:0];
  assign axi00_ptr0 = ptr_q[C_M_AXI_ADDR_WIDTH-1:0];

  // ------------------------------------------------------------ interrupts
`ifdef BYTESWAP_CTRL_IRQ_EN
  logic       gier;
  logic [1:0] ier;
  logic [1:0] isr;
  logic [1:0] isr_toggle;
  logic       irq_q;

  assign isr_toggle = (w_hs && (wr_addr == AW'(ADDR_ISR)) && s_axi_control_wstrb[0])
                      ? s_axi_control_wdata[1:0] : 2'b00;

  // ISR bit 0 tracks ap_done, bit 1 tracks ap_ready; an enabled event overrides a toggle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      gier  <= 1'b0;
      ier   <= 2'b00;
      isr   <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      if (w_hs && (wr_addr == AW'(ADDR_GIER)) && s_axi_control_wstrb[0])
        gier <= s_axi_control_wdata[0];
      if (w_hs && (wr_addr == AW'(ADDR_IER)) && s_axi_control_wstrb[0])
        ier <= s_axi_control_wdata[1:0];
      isr   <= (isr ^ isr_toggle) | ({ap_ready, ap_done} & ier);
      irq_q <= gier && (|isr);
    end
  end

  assign interrupt = irq_q;
`else
  assign interrupt = 1'b0;
`endif

  // ------------------------------------------------------------ read mux
  always_comb begin
    rdata_n = '0;
    case (s_axi_control_araddr)
      AW'(ADDR_CTRL): begin
        rdata_n[CTRL_AP_START]     = ap_start_q;
        rdata_n[CTRL_DONE_STICKY]  = done_sticky;
        rdata_n[CTRL_AP_IDLE]      = ap_idle;
        rdata_n[CTRL_AP_READY]     = ap_ready;
        rdata_n[CTRL_AUTO_RESTART] = auto_restart;
      end
`ifdef BYTESWAP_CTRL_IRQ_EN
      AW'(ADDR_GIER): rdata_n[0]   = gier;
      AW'(ADDR_IER):  rdata_n[1:0] = ier;
      AW'(ADDR_ISR):  rdata_n[1:0] = isr;
`endif
      AW'(ADDR_SCALAR00): rdata_n = scalar_q;
      AW'(ADDR_PTR0_LO):  rdata_n = ptr_q[31:0];
      AW'(ADDR_PTR0_HI):  rdata_n = ptr_q[63:32];
      default:            rdata_n = '0;
    endcase
  end

  // Captured at the AR handshake and frozen until the beat is accepted.
  always_ff @(posedge aclk) begin
    if (areset)     rdata_q <= '0;
    else if (ar_hs) rdata_q <= rdata_n;
  end

endmodule
